countdown_seq_ctrl: RTL and testbench

- Controller/sequencer for the 4-bit down-counter datapath.
- Loads a programmable start value and decrements it on prescaled ticks.
- Supports pause and abort; flags terminal count with a done/ack handshake.
- Sits between the lab's switch/button front end and the counter display; owns all load, clear and enable sequencing of the count register.

---
 rtl/countdown_pkg.sv | 20 ++
 rtl/countdown_tick_gen.sv | 35 +++
 rtl/countdown_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_countdown_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer family: FSM state encoding,
// default datapath width and the legal prescaler range.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int PRESCALE_MIN  = 1;
  localparam int PRESCALE_MAX  = 255;

  // A prescale of 1 still needs a 1-bit phase register so the port stays legal.
  function automatic int prescale_bits(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and asserts tick on the last
// phase. clr has priority over en; progress is frozen while en is low.
module countdown_tick_gen
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = prescale_bits(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // Combinational so the owner can act on the same edge the phase wraps.
  assign tick = en && (phase == LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_seq_ctrl.sv
// Countdown sequencer: loads a start value, decrements on prescaled ticks,
// supports pause/abort and a done/ack handshake at terminal count.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: periodic reload instead of DONE.
module countdown_seq_ctrl
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr_bar,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             tc_nxt;
  logic             do_load;
  logic             tick, tick_en, tick_clr;

  // Prescaler only advances in RUN; it is held at phase 0 everywhere else so
  // every run starts a full prescale period after the load.
  assign tick_en  = (state == ST_RUN) && !pause && !abort;
  assign tick_clr = (state != ST_RUN) || abort;

  countdown_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (clr_bar),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      state    <= ST_IDLE;
      count    <= '0;
      reload   <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      reload   <= reload_nxt;
      tc_pulse <= tc_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    do_load    = 1'b0;

    if (abort) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: do_load = start;

        ST_RUN: begin
          if (tick) begin
            if (count > ONE) begin
              count_nxt = count - ONE;
            end else if (count == ONE) begin
              count_nxt = '0;
              tc_nxt    = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
              state_nxt = ST_DONE;
`endif
            end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // Count sat at 0 for one period; start the next period.
              count_nxt = reload;
              if (reload == '0) state_nxt = ST_DONE;
`else
              state_nxt = ST_DONE;
`endif
            end
          end
        end

        ST_DONE: begin
          if (ack) begin
            if (start) do_load   = 1'b1;
            else       state_nxt = ST_IDLE;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase

      // A zero start value has nothing to count: terminal count immediately.
      if (do_load) begin
        count_nxt  = load_val;
        reload_nxt = load_val;
        if (load_val == '0) begin
          state_nxt = ST_DONE;
          tc_nxt    = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Self-checking bench: two instances (PRESCALE 1 and 3) share stimulus and are
// compared every cycle against an elapsed-active-cycles reference model.
module tb_countdown_seq_ctrl;

  localparam int P_A = 1;
  localparam int P_B = 3;

  logic       clk = 1'b0;
  logic       clr_bar;
  logic       start, pause, abort, ack;
  logic [3:0] load_val;

  logic [3:0] count_a, count_b;
  logic       busy_a, busy_b, done_a, done_b, tc_a, tc_b;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state, index 0 = P_A instance, 1 = P_B instance.
  int pre    [2] = '{P_A, P_B};
  int m_mode [2];  // 0 idle, 1 run, 2 done
  int m_n    [2];
  int m_act  [2];  // unpaused RUN cycles since load
  int m_cnt  [2];
  int m_tc   [2];

  always #5 clk = ~clk;

  countdown_seq_ctrl #(.WIDTH(4), .PRESCALE(P_A)) u_dut_a (
    .clk(clk), .clr_bar(clr_bar), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .ack(ack),
    .count(count_a), .busy(busy_a), .done(done_a), .tc_pulse(tc_a)
  );

  countdown_seq_ctrl #(.WIDTH(4), .PRESCALE(P_B)) u_dut_b (
    .clk(clk), .clr_bar(clr_bar), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .ack(ack),
    .count(count_b), .busy(busy_b), .done(done_b), .tc_pulse(tc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_n[i] = 0; m_act[i] = 0; m_cnt[i] = 0; m_tc[i] = 0;
    end
  endtask

  task automatic model_load(input int i);
    m_n[i]   = int'(load_val);
    m_act[i] = 0;
    m_cnt[i] = m_n[i];
    if (m_n[i] == 0) begin
      m_mode[i] = 2;
      m_tc[i]   = 1;
    end else begin
      m_mode[i] = 1;
    end
  endtask

  task automatic model_step(input int i);
    m_tc[i] = 0;
    if (abort) begin
      m_mode[i] = 0;
      m_cnt[i]  = 0;
    end else begin
      case (m_mode[i])
        0: if (start) model_load(i);
        1: if (!pause) begin
          m_act[i]++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (m_act[i] == (m_n[i] + 1) * pre[i]) m_act[i] = 0;
          m_cnt[i] = m_n[i] - m_act[i] / pre[i];
          if (m_act[i] == m_n[i] * pre[i]) m_tc[i] = 1;
`else
          m_cnt[i] = m_n[i] - m_act[i] / pre[i];
          if (m_act[i] == m_n[i] * pre[i]) begin
            m_mode[i] = 2;
            m_tc[i]   = 1;
          end
`endif
        end
        default: if (ack) begin
          if (start) model_load(i);
          else       m_mode[i] = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("count_a", count_a, m_cnt[0]);
    check("busy_a",  busy_a,  m_mode[0] == 1);
    check("done_a",  done_a,  m_mode[0] == 2);
    check("tc_a",    tc_a,    m_tc[0]);
    check("count_b", count_b, m_cnt[1]);
    check("busy_b",  busy_b,  m_mode[1] == 1);
    check("done_b",  done_b,  m_mode[1] == 2);
    check("tc_b",    tc_b,    m_tc[1]);
  endtask

  // One clock: model advances on the edge with the pre-edge inputs, outputs
  // are compared on the following falling edge where new inputs are driven.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic go_idle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  int lat;
  int tc_seen;

  initial begin
    clr_bar = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; ack = 1'b0;
    load_val = '0;
    model_reset();
    #3 check_all();
    repeat (2) @(negedge clk);
    clr_bar = 1'b1;
    cycle();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic reload: 3,2,1,0,3,... with tc every 4 cycles and no done.
    load_val = 4'd3; start = 1'b1;
    cycle();
    start = 1'b0; tc_seen = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (tc_a) tc_seen++;
      check("auto_no_done", done_a, 1'b0);
    end
    check("auto_tc_count", tc_seen, 3);
    go_idle();
`else
    // Basic countdown, prescale 1: done rises 6 cycles after start.
    load_val = 4'd5; start = 1'b1; lat = 1;
    cycle();
    start = 1'b0;
    while (!done_a && lat < 40) begin cycle(); lat++; end
    check("basic_lat", lat, 6);
    check("basic_tc", tc_a, 1'b1);
    repeat (3) cycle();
    check("basic_hold", done_a, 1'b1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    check("basic_ack_idle", done_a, 1'b0);
    go_idle();

    // Prescale 3 with a 4-cycle pause at count 2: 10 -> 14 cycles.
    load_val = 4'd3; start = 1'b1; lat = 1;
    cycle();
    start = 1'b0;
    while (count_b != 4'd2 && lat < 20) begin cycle(); lat++; end
    check("pause_at2_lat", lat, 4);
    pause = 1'b1;
    repeat (4) begin cycle(); lat++; end
    check("pause_hold", count_b, 4'd2);
    pause = 1'b0;
    while (!done_b && lat < 60) begin cycle(); lat++; end
    check("pause_lat", lat, 14);
    go_idle();

    // Zero start value, then restart from DONE with start+ack.
    load_val = 4'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("zero_done", done_a, 1'b1);
    check("zero_tc", tc_a, 1'b1);
    cycle();
    load_val = 4'd2; start = 1'b1; ack = 1'b1;
    cycle();
    start = 1'b0; ack = 1'b0;
    check("restart_count", count_a, 4'd2);
    check("restart_busy", busy_a, 1'b1);
    go_idle();

    // Full-scale value counts down without underflow and holds 0 in DONE.
    load_val = 4'hF; start = 1'b1; lat = 1;
    cycle();
    start = 1'b0;
    while (!done_a && lat < 40) begin cycle(); lat++; end
    check("max_lat", lat, 16);
    repeat (3) cycle();
    check("max_hold0", count_a, 4'd0);
    go_idle();
`endif

    // Abort mid-count returns to IDLE with count cleared.
    load_val = 4'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    check("abort_pre", count_a, 4'd7);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_count", count_a, 4'd0);
    check("abort_busy", busy_a, 1'b0);

    // Asynchronous reset mid-run takes effect without a clock edge.
    load_val = 4'd8; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    check("rst_pre", count_a, 4'd5);
    #2 clr_bar = 1'b0;
    model_reset();
    #1 check_all();
    check("rst_count", count_a, 4'd0);
    check("rst_busy", busy_a, 1'b0);
    #1 clr_bar = 1'b1;
    cycle();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      start    = ($urandom_range(99) < 30);
      load_val = 4'($urandom_range(15));
      pause    = ($urandom_range(99) < 25);
      abort    = ($urandom_range(99) < 3);
      ack      = ($urandom_range(99) < 20);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
